// File: rtl/multicycle_core_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_core_sequencer
//
// Main control FSM of the multicycle RV32I core. Every instruction walks
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block drives the
// datapath enables and mux selects, hands the instruction class code
// (alu_option) to the ALU controller, talks to a variable-latency memory
// through a req/ready handshake, traps unsupported opcodes and counts
// retired instructions.
//
// Ports:
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          leaves IDLE (after reset when RESET_STATE_FETCH=0, or after a trap)
//   opcode         instr[6:0] from the instruction register, valid from DECODE on
//   branch_cond    ALU comparison result, 1 = branch taken (EXEC of branches)
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request, held until mem_ready
//   mem_we         1 = store, 0 = read
//   mem_addr_sel   0 = PC (fetch), 1 = ALU result (data access)
//   ir_write       latch fetched word into the instruction register
//   pc_write       update PC (asserted exactly when an instruction retires)
//   pc_src         00 = PC+4, 01 = PC+imm, 10 = ALU result & ~1 (JALR)
//   alu_src_a      00 = rs1, 01 = PC, 10 = zero
//   alu_src_b      0 = rs2, 1 = immediate
//   alu_option     instruction class code for the ALU controller
//   reg_write      register-file write enable
//   wb_sel         00 = ALU result, 01 = memory data, 10 = PC+4
//   illegal_instr  one-cycle pulse on an unsupported opcode
//   instret        retired-instruction count, wraps modulo 2^INSTRET_W
// -----------------------------------------------------------------------------
module multicycle_core_sequencer #(
   parameter bit RESET_STATE_FETCH = 1'b1,
   parameter int INSTRET_W         = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [6:0]           opcode,
   input  logic                 branch_cond,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_addr_sel,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic [1:0]           alu_src_a,
   output logic                 alu_src_b,
   output logic [3:0]           alu_option,
   output logic                 reg_write,
   output logic [1:0]           wb_sel,
   output logic                 illegal_instr,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   state_t               state_reg;
   logic [INSTRET_W-1:0] instret_reg;

   // opcode classification
   logic       is_ld, is_st, is_opi, is_op, is_lui, is_auipc, is_br, is_jal, is_jalr;
   logic       is_legal;
   logic [3:0] class_opt;

   always_comb begin
      is_ld    = (opcode == OPC_LD);
      is_st    = (opcode == OPC_ST);
      is_opi   = (opcode == OPC_OPI);
      is_op    = (opcode == OPC_OP);
      is_lui   = (opcode == OPC_LUI);
      is_auipc = (opcode == OPC_AUIPC);
      is_br    = (opcode == OPC_BR);
      is_jal   = (opcode == OPC_JAL);
      is_jalr  = (opcode == OPC_JALR);
      is_legal = is_ld | is_st | is_opi | is_op | is_lui | is_auipc |
                 is_br | is_jal | is_jalr;

      class_opt = 4'b0000;
      if (is_opi)            class_opt = 4'b0010;
      if (is_auipc)          class_opt = 4'b0011;
      if (is_st)             class_opt = 4'b0100;
      if (is_op)             class_opt = 4'b0110;
      if (is_lui)            class_opt = 4'b0111;
      if (is_br)             class_opt = 4'b1100;
      if (is_jal || is_jalr) class_opt = 4'b1101;
   end

   // Output decode, before reset gating
   logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_write_c, pc_write_c;
   logic [1:0] pc_src_c, alu_src_a_c, wb_sel_c;
   logic       alu_src_b_c, reg_write_c, illegal_c;
   logic [3:0] alu_option_c;

   always_comb begin
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = 2'b00;
      alu_src_a_c    = 2'b00;
      alu_src_b_c    = 1'b0;
      alu_option_c   = 4'b0000;
      reg_write_c    = 1'b0;
      wb_sel_c       = 2'b00;
      illegal_c      = 1'b0;

      case (state_reg)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            ir_write_c = mem_ready;
         end
         S_EXEC: begin
            alu_option_c = class_opt;
            if (is_ld || is_st || is_opi || is_jalr) begin
               alu_src_b_c = 1'b1;
            end else if (is_auipc || is_jal) begin
               alu_src_a_c = 2'b01;
               alu_src_b_c = 1'b1;
            end else if (is_lui) begin
               alu_src_a_c = 2'b10;
               alu_src_b_c = 1'b1;
            end
            // branches resolve and retire here
            if (is_br) begin
               pc_write_c = 1'b1;
               pc_src_c   = branch_cond ? 2'b01 : 2'b00;
            end
         end
         S_MEM: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = is_st;
            alu_option_c   = class_opt;
            // a store retires in the same cycle its write handshake completes
            if (is_st && mem_ready) begin
               pc_write_c = 1'b1;
            end
         end
         S_WB: begin
            reg_write_c  = 1'b1;
            pc_write_c   = 1'b1;
            alu_option_c = class_opt;
            if (is_ld)                 wb_sel_c = 2'b01;
            else if (is_jal || is_jalr) wb_sel_c = 2'b10;
            if (is_jal)       pc_src_c = 2'b01;
            else if (is_jalr) pc_src_c = 2'b10;
         end
         S_TRAP: begin
            illegal_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Gate with rst_n so an in-flight request or write drops the instant
   // reset is asserted, without waiting for a clock edge.
   assign mem_req       = rst_n & mem_req_c;
   assign mem_we        = rst_n & mem_we_c;
   assign mem_addr_sel  = rst_n & mem_addr_sel_c;
   assign ir_write      = rst_n & ir_write_c;
   assign pc_write      = rst_n & pc_write_c;
   assign pc_src        = rst_n ? pc_src_c : 2'b00;
   assign alu_src_a     = rst_n ? alu_src_a_c : 2'b00;
   assign alu_src_b     = rst_n & alu_src_b_c;
   assign alu_option    = rst_n ? alu_option_c : 4'b0000;
   assign reg_write     = rst_n & reg_write_c;
   assign wb_sel        = rst_n ? wb_sel_c : 2'b00;
   assign illegal_instr = rst_n & illegal_c;
   assign instret       = instret_reg;

   // State sequencing and retire counting. pc_write_c is asserted exactly
   // on the retiring cycle of every instruction, so it doubles as the
   // retire strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
         instret_reg <= '0;
      end else begin
         if (pc_write_c) begin
            instret_reg <= instret_reg + INSTRET_W'(1);
         end
         case (state_reg)
            S_IDLE:   if (start) state_reg <= S_FETCH;
            S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
            S_DECODE: state_reg <= is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
               if (is_ld || is_st) state_reg <= S_MEM;
               else if (is_br)     state_reg <= S_FETCH;
               else                state_reg <= S_WB;
            end
            S_MEM: begin
               if (mem_ready) state_reg <= is_st ? S_FETCH : S_WB;
            end
            S_WB:     state_reg <= S_FETCH;
            S_TRAP:   state_reg <= S_IDLE;
            default:  state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core_sequencer.sv
module tb_multicycle_core_sequencer;

   localparam int IW = 4;   // narrow counter so wrap-around is exercised

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [6:0]    opcode = 7'd0;
   logic          branch_cond = 1'b0;
   logic          mem_ready = 1'b0;
   logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
   logic [1:0]    pc_src, alu_src_a, wb_sel;
   logic          alu_src_b, reg_write, illegal_instr;
   logic [3:0]    alu_option;
   logic [IW-1:0] instret;

   always #5 clk = ~clk;

   multicycle_core_sequencer #(
      .RESET_STATE_FETCH(1'b1),
      .INSTRET_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .branch_cond(branch_cond), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_option(alu_option),
      .reg_write(reg_write), .wb_sel(wb_sel), .illegal_instr(illegal_instr),
      .instret(instret)
   );

   // [17]req [16]we [15]asel [14]irw [13]pcw [12:11]pcs [10:9]srca [8]srcb
   // [7:4]opt [3]rw [2:1]wbs [0]ill
   logic [17:0] dut_vec;
   assign dut_vec = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                     alu_src_a, alu_src_b, alu_option, reg_write, wb_sel, illegal_instr};

   int            checks = 0;
   int            errors = 0;
   logic [IW-1:0] model_instret = '0;
   logic [17:0]   snap;

   logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                                 7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111,
                                 7'b1100111};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] mk(input logic mreq, input logic mwe, input logic masel,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic [1:0] asa, input logic asb, input logic [3:0] opt,
                                      input logic rw, input logic [1:0] wbs, input logic ill);
      return {mreq, mwe, masel, irw, pcw, pcs, asa, asb, opt, rw, wbs, ill};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit supported(input logic [6:0] op);
      foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] opt_of(input logic [6:0] op);
      case (op)
         7'b0000011: return 4'b0000;
         7'b0010011: return 4'b0010;
         7'b0010111: return 4'b0011;
         7'b0100011: return 4'b0100;
         7'b0110011: return 4'b0110;
         7'b0110111: return 4'b0111;
         7'b1100011: return 4'b1100;
         default:    return 4'b1101;   // JAL / JALR
      endcase
   endfunction

   // One clock cycle: drive at the falling edge, compare 1 time unit later.
   task automatic step(input logic [6:0] op, input logic bc, input logic mr, input logic st,
                       input logic [17:0] exp, input string nm);
      @(negedge clk);
      opcode = op; branch_cond = bc; mem_ready = mr; start = st;
      #1;
      snap = dut_vec;
      check(nm, 32'(dut_vec), 32'(exp));
      check({nm, "_instret"}, 32'(instret), 32'(model_instret));
   endtask

   // Reference model at instruction level: builds the expected per-cycle
   // control vector from the instruction class, stall counts and branch
   // outcome. Reports the DUT-observed cycle of retirement (first pc_write)
   // and the DUT's alu_option in EXEC, wb_sel/pc_src on the last cycle.
   task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic bc,
                            output int dut_cycles, output logic [3:0] exec_opt,
                            output logic [1:0] last_wbs, output logic [1:0] last_pcs);
      int         n;
      logic [3:0] opt;
      logic [1:0] asa, pcs;
      logic       asb, is_ld, is_st, is_br, mr;
      n = 0; dut_cycles = 0; exec_opt = 4'h0;
      for (int i = 0; i <= fs; i++) begin
         mr = (i == fs);
         step(7'($urandom), rb(), mr, rb(), mk(1, 0, 0, mr, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
         n++;
      end
      step(op, rb(), rb(), rb(), 18'd0, "decode");
      n++;
      if (!supported(op)) begin
         step(op, rb(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "trap");
         n++;
         last_wbs = snap[2:1]; last_pcs = snap[12:11];
         return;
      end
      opt   = opt_of(op);
      is_ld = (op == 7'b0000011);
      is_st = (op == 7'b0100011);
      is_br = (op == 7'b1100011);
      case (op)
         7'b0110011, 7'b1100011: begin asa = 2'b00; asb = 1'b0; end
         7'b0010111, 7'b1101111: begin asa = 2'b01; asb = 1'b1; end
         7'b0110111:             begin asa = 2'b10; asb = 1'b1; end
         default:                begin asa = 2'b00; asb = 1'b1; end
      endcase
      pcs = (is_br && bc) ? 2'b01 : 2'b00;
      step(op, is_br ? bc : rb(), rb(), rb(),
           mk(0, 0, 0, 0, is_br, pcs, asa, asb, opt, 0, 0, 0), "exec");
      n++;
      exec_opt = snap[7:4];
      if (snap[13] && dut_cycles == 0) dut_cycles = n;
      if (is_br) begin
         model_instret++;
         last_wbs = snap[2:1]; last_pcs = snap[12:11];
         return;
      end
      if (is_ld || is_st) begin
         for (int i = 0; i <= ms; i++) begin
            mr = (i == ms);
            step(op, rb(), mr, rb(), mk(1, is_st, 1, 0, is_st && mr, 0, 0, 0, opt, 0, 0, 0), "mem");
            n++;
            if (snap[13] && dut_cycles == 0) dut_cycles = n;
         end
         if (is_st) begin
            model_instret++;
            last_wbs = snap[2:1]; last_pcs = snap[12:11];
            return;
         end
      end
      pcs = (op == 7'b1101111) ? 2'b01 : (op == 7'b1100111) ? 2'b10 : 2'b00;
      step(op, rb(), rb(), rb(),
           mk(0, 0, 0, 0, 1, pcs, 0, 0, opt, 1,
              is_ld ? 2'b01 : (opt == 4'b1101) ? 2'b10 : 2'b00, 0), "wb");
      n++;
      if (snap[13] && dut_cycles == 0) dut_cycles = n;
      model_instret++;
      last_wbs = snap[2:1]; last_pcs = snap[12:11];
   endtask

   // Sit in IDLE for k cycles with start low, then pulse start.
   task automatic idle_start(input int k);
      for (int i = 0; i < k; i++) step(7'($urandom), rb(), rb(), 1'b0, 18'd0, "idle");
      step(7'($urandom), rb(), rb(), 1'b1, 18'd0, "idle_start");
   endtask

   typedef struct {
      logic [6:0] op;
      int         fs;
      int         ms;
      logic       bc;
      int         cyc;
      logic [3:0] opt;
      logic [1:0] wbs;
      logic [1:0] pcs;
      string      nm;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      logic [3:0] eo;
      logic [1:0] lw, lp;
      logic [6:0] op;

      vecs[0] = '{7'b0010011, 0, 0, 1'b0,  4, 4'b0010, 2'b00, 2'b00, "addi"};
      vecs[1] = '{7'b0000011, 3, 2, 1'b0, 10, 4'b0000, 2'b01, 2'b00, "lw_stall"};
      vecs[2] = '{7'b1100011, 0, 0, 1'b1,  3, 4'b1100, 2'b00, 2'b01, "beq_taken"};
      vecs[3] = '{7'b1100011, 0, 0, 1'b0,  3, 4'b1100, 2'b00, 2'b00, "beq_not"};
      vecs[4] = '{7'b0100011, 0, 0, 1'b0,  4, 4'b0100, 2'b00, 2'b00, "sw"};
      vecs[5] = '{7'b1100111, 0, 0, 1'b0,  4, 4'b1101, 2'b10, 2'b10, "jalr"};
      vecs[6] = '{7'b1101111, 1, 0, 1'b0,  5, 4'b1101, 2'b10, 2'b01, "jal"};
      vecs[7] = '{7'b0110111, 0, 0, 1'b0,  4, 4'b0111, 2'b00, 2'b00, "lui"};
      vecs[8] = '{7'b0010111, 0, 0, 1'b0,  4, 4'b0011, 2'b00, 2'b00, "auipc"};
      vecs[9] = '{7'b0110011, 2, 1, 1'b0,  6, 4'b0110, 2'b00, 2'b00, "op_stall"};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_vec", 32'(dut_vec), 32'd0);
      check("reset_instret", 32'(instret), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed table
      for (int v = 0; v < 10; v++) begin
         run_instr(vecs[v].op, vecs[v].fs, vecs[v].ms, vecs[v].bc, cyc, eo, lw, lp);
         check({vecs[v].nm, "_cycles"}, 32'(cyc), 32'(vecs[v].cyc));
         check({vecs[v].nm, "_exec_opt"}, 32'(eo), 32'(vecs[v].opt));
         check({vecs[v].nm, "_wb_sel"}, 32'(lw), 32'(vecs[v].wbs));
         check({vecs[v].nm, "_pc_src"}, 32'(lp), 32'(vecs[v].pcs));
         $display("vec %0d %s cycles=%0d instret=%0d", v, vecs[v].nm, cyc, instret);
      end

      // illegal opcode: single trap pulse, sticky IDLE until start
      run_instr(7'b1111111, 0, 0, 1'b0, cyc, eo, lw, lp);
      $display("trap opcode=7f");
      idle_start(3);
      run_instr(7'b0010011, 0, 0, 1'b0, cyc, eo, lw, lp);
      check("after_trap_cycles", 32'(cyc), 32'd4);

      // reset during a store's MEM stall
      step(7'($urandom), 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_fetch");
      step(7'b0100011, 0, 0, 0, 18'd0, "rst_decode");
      step(7'b0100011, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 0, 0, 0), "rst_exec");
      step(7'b0100011, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b0100, 0, 0, 0), "rst_mem_stall");
      rst_n = 1'b0;
      #1;
      model_instret = '0;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_vec", 32'(dut_vec), 32'd0);
      check("rst_instret", 32'(instret), 32'd0);
      mem_ready = 1'b1;   // would complete the store if reset were ignored
      @(negedge clk);
      #1;
      check("rst_hold_vec", 32'(dut_vec), 32'd0);
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(7'($urandom), 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_fetch");
      $display("reset mid-store instret=%0d", instret);
      // finish that fetch
      step(7'($urandom), 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_fetch2");
      step(7'b0110011, 0, 0, 0, 18'd0, "post_rst_decode");
      step(7'b0110011, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 0, 0), "post_rst_exec");
      step(7'b0110011, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 4'b0110, 1, 0, 0), "post_rst_wb");
      model_instret++;

      // randomized instruction stream (counter wraps at 16)
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 9) < 9) begin
            op = legal_ops[$urandom_range(0, 8)];
         end else begin
            op = 7'($urandom);
            while (supported(op)) op = 7'($urandom);
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(), cyc, eo, lw, lp);
         $display("rand %0d op=%b cycles=%0d instret=%0d", t, op, cyc, instret);
         if (!supported(op)) idle_start($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
